// File: rtl/pulse_monitor_pkg.sv
// Shared types for the pulse_monitor receiver: FSM state encoding and the
// width of the completed-measurement counter.
package pulse_monitor_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_EDGE,
      IN_PULSE,
      REPORT
   } pm_state_e;

   localparam int unsigned PULSE_COUNT_W = 8;

endpackage

// File: rtl/pulse_edge_sync.sv
// Multi-stage synchronizer for an asynchronous pulse line, with a
// previous-sample register giving leading/trailing edge strobes.
module pulse_edge_sync
   import pulse_monitor_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        IDLE_LEVEL  = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pulse_i,
   output logic level_o,
   output logic lead_o,
   output logic trail_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   prev_q;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], pulse_i};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
         prev_q <= IDLE_LEVEL;
      end else begin
         sync_q <= sync_d;
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign lead_o  = (level_o != IDLE_LEVEL) && (prev_q == IDLE_LEVEL);
   assign trail_o = (level_o == IDLE_LEVEL) && (prev_q != IDLE_LEVEL);

endmodule

// File: rtl/pulse_monitor.sv
// Arm-triggered pulse delay/width monitor with valid/ready result handshake.
// Optional glitch rejection below MIN_WIDTH: PULSE_MONITOR_GLITCH_FILTER_EN.
module pulse_monitor
   import pulse_monitor_pkg::*;
#(
   parameter logic        IDLE_LEVEL         = 1'b0,
   parameter int unsigned SYNC_STAGES        = 2,
   parameter int unsigned DELAY_COUNTER_SIZE = 16,
   parameter int unsigned WIDTH_COUNTER_SIZE = 10,
   parameter int unsigned MIN_WIDTH          = 1
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          arm,
   input  logic                          pulse_in,
   output logic                          busy,
   output logic                          result_valid,
   input  logic                          result_ready,
   output logic [DELAY_COUNTER_SIZE-1:0] delay_cycles,
   output logic [WIDTH_COUNTER_SIZE-1:0] width_cycles,
   output logic                          width_overflow,
   output logic                          timeout,
   output logic [PULSE_COUNT_W-1:0]      pulse_count
);

`ifdef PULSE_MONITOR_GLITCH_FILTER_EN
   localparam bit FILTER_EN = 1'b1;
`else
   localparam bit FILTER_EN = 1'b0;
`endif

   localparam logic [DELAY_COUNTER_SIZE-1:0] DELAY_MAX = '1;
   localparam logic [WIDTH_COUNTER_SIZE-1:0] WIDTH_MAX = '1;
   localparam logic [WIDTH_COUNTER_SIZE-1:0] MIN_W     = WIDTH_COUNTER_SIZE'(MIN_WIDTH);
   localparam int unsigned SUM_W =
      ((DELAY_COUNTER_SIZE > WIDTH_COUNTER_SIZE) ? DELAY_COUNTER_SIZE : WIDTH_COUNTER_SIZE) + 1;

   pm_state_e                     state_q;
   logic                          busy_q;
   logic                          valid_q;
   logic [DELAY_COUNTER_SIZE-1:0] delay_q;
   logic [WIDTH_COUNTER_SIZE-1:0] width_q;
   logic                          ovf_q;
   logic                          timeout_q;
   logic [PULSE_COUNT_W-1:0]      count_q;

   logic                          s_level;
   logic                          lead_edge;
   logic                          trail_edge;

   logic [DELAY_COUNTER_SIZE-1:0] delay_step_d;
   logic [SUM_W-1:0]              resume_sum;
   logic [DELAY_COUNTER_SIZE-1:0] delay_resume_d;
   logic                          glitch_reject;

   pulse_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .IDLE_LEVEL  (IDLE_LEVEL)
   ) u_sync (
      .clk_i   (clk_in),
      .rst_i   (rst_in),
      .pulse_i (pulse_in),
      .level_o (s_level),
      .lead_o  (lead_edge),
      .trail_o (trail_edge)
   );

   // A discarded glitch folds its cycles (edge cycle .. trailing cycle) back
   // into the delay so the count stays referenced to arm acceptance.
   always_comb begin
      delay_step_d   = (delay_q == DELAY_MAX) ? DELAY_MAX : delay_q + 1'b1;
      resume_sum     = SUM_W'(delay_q) + SUM_W'(width_q) + SUM_W'(1);
      delay_resume_d = (resume_sum >= SUM_W'(DELAY_MAX)) ? DELAY_MAX
                                                         : resume_sum[DELAY_COUNTER_SIZE-1:0];
      glitch_reject  = FILTER_EN && (width_q < MIN_W);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= IDLE;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         delay_q   <= '0;
         width_q   <= '0;
         ovf_q     <= 1'b0;
         timeout_q <= 1'b0;
         count_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (arm) begin
                  state_q   <= WAIT_EDGE;
                  busy_q    <= 1'b1;
                  delay_q   <= '0;
                  width_q   <= '0;
                  ovf_q     <= 1'b0;
                  timeout_q <= 1'b0;
               end
            end
            WAIT_EDGE: begin
               if (lead_edge) begin
                  state_q <= IN_PULSE;
                  width_q <= WIDTH_COUNTER_SIZE'(1);
               end else begin
                  delay_q <= delay_step_d;
                  if (delay_step_d == DELAY_MAX) begin
                     state_q   <= REPORT;
                     valid_q   <= 1'b1;
                     timeout_q <= 1'b1;
                     width_q   <= '0;
                  end
               end
            end
            IN_PULSE: begin
               if (trail_edge) begin
                  if (glitch_reject) begin
                     state_q <= WAIT_EDGE;
                     delay_q <= delay_resume_d;
                     width_q <= '0;
                  end else begin
                     state_q <= REPORT;
                     valid_q <= 1'b1;
                  end
               end else if (width_q == WIDTH_MAX) begin
                  ovf_q <= 1'b1;
               end else begin
                  width_q <= width_q + 1'b1;
               end
            end
            REPORT: begin
               if (result_ready) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  if (!timeout_q) begin
                     count_q <= count_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy           = busy_q;
   assign result_valid   = valid_q;
   assign delay_cycles   = delay_q;
   assign width_cycles   = width_q;
   assign width_overflow = ovf_q;
   assign timeout        = timeout_q;
   assign pulse_count    = count_q;

endmodule

// File: tb/tb_pulse_monitor.sv
// Directed bench for pulse_monitor: one default-size instance (MIN_WIDTH=3)
// and one with 4-bit delay / 3-bit width counters for boundary cases.
module tb_pulse_monitor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   // Instance A: default counter sizes
   logic        rst_a, arm_a, pulse_a, ready_a;
   logic        busy_a, valid_a, ovf_a, to_a;
   logic [15:0] delay_a;
   logic [9:0]  width_a;
   logic [7:0]  cnt_a;

   // Instance B: small counters
   logic        rst_b, arm_b, pulse_b, ready_b;
   logic        busy_b, valid_b, ovf_b, to_b;
   logic [3:0]  delay_b;
   logic [2:0]  width_b;
   logic [7:0]  cnt_b;

   int exp_delay;
   int exp_width;

   pulse_monitor #(
      .MIN_WIDTH (3)
   ) dut_a (
      .clk_in         (clk),
      .rst_in         (rst_a),
      .arm            (arm_a),
      .pulse_in       (pulse_a),
      .busy           (busy_a),
      .result_valid   (valid_a),
      .result_ready   (ready_a),
      .delay_cycles   (delay_a),
      .width_cycles   (width_a),
      .width_overflow (ovf_a),
      .timeout        (to_a),
      .pulse_count    (cnt_a)
   );

   pulse_monitor #(
      .DELAY_COUNTER_SIZE (4),
      .WIDTH_COUNTER_SIZE (3)
   ) dut_b (
      .clk_in         (clk),
      .rst_in         (rst_b),
      .arm            (arm_b),
      .pulse_in       (pulse_b),
      .busy           (busy_b),
      .result_valid   (valid_b),
      .result_ready   (ready_b),
      .delay_cycles   (delay_b),
      .width_cycles   (width_b),
      .width_overflow (ovf_b),
      .timeout        (to_b),
      .pulse_count    (cnt_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_a = 1'b1; arm_a = 1'b0; pulse_a = 1'b0; ready_a = 1'b0;
      rst_b = 1'b1; arm_b = 1'b0; pulse_b = 1'b0; ready_b = 1'b0;
      repeat (3) tick();
      rst_a = 1'b0;
      rst_b = 1'b0;

      // Reset state
      chk("rst_busy",  32'(busy_a),  0);
      chk("rst_valid", 32'(valid_a), 0);
      chk("rst_delay", 32'(delay_a), 0);
      chk("rst_width", 32'(width_a), 0);
      chk("rst_flags", 32'({ovf_a, to_a}), 0);
      chk("rst_count", 32'(cnt_a), 0);

      // Basic measurement: pulse of 5 cycles, 10 cycles after arm
      arm_a = 1'b1;
      tick();
      arm_a = 1'b0;
      chk("t1_busy", 32'(busy_a), 1);
      repeat (9) tick();
      pulse_a = 1'b1;
      repeat (5) tick();
      pulse_a = 1'b0;
      repeat (2) tick();
      chk("t1_not_yet", 32'(valid_a), 0);
      tick();
      chk("t1_valid",   32'(valid_a), 1);
      chk("t1_delay",   32'(delay_a), 11);
      chk("t1_width",   32'(width_a), 5);
      chk("t1_timeout", 32'(to_a),    0);
      chk("t1_ovf",     32'(ovf_a),   0);
      ready_a = 1'b1;
      tick();
      ready_a = 1'b0;
      chk("t1_ack_valid", 32'(valid_a), 0);
      chk("t1_ack_busy",  32'(busy_a),  0);
      chk("t1_count",     32'(cnt_a),   1);
      chk("t1_hold",      32'(delay_a), 11);

      // Timeout with 4-bit delay counter
      arm_b = 1'b1;
      tick();
      arm_b = 1'b0;
      repeat (14) tick();
      chk("t2_not_yet", 32'(valid_b), 0);
      chk("t2_busy",    32'(busy_b),  1);
      tick();
      chk("t2_valid",   32'(valid_b), 1);
      chk("t2_timeout", 32'(to_b),    1);
      chk("t2_width",   32'(width_b), 0);
      chk("t2_delay",   32'(delay_b), 15);
      ready_b = 1'b1;
      tick();
      ready_b = 1'b0;
      chk("t2_ack_valid", 32'(valid_b), 0);
      chk("t2_count",     32'(cnt_b),   0);

      // Width saturation with 3-bit width counter, 12-cycle pulse
      arm_b = 1'b1;
      tick();
      arm_b = 1'b0;
      tick();
      pulse_b = 1'b1;
      repeat (12) tick();
      pulse_b = 1'b0;
      repeat (2) tick();
      chk("t3_not_yet", 32'(valid_b), 0);
      chk("t3_busy",    32'(busy_b),  1);
      tick();
      chk("t3_valid", 32'(valid_b), 1);
      chk("t3_width", 32'(width_b), 7);
      chk("t3_ovf",   32'(ovf_b),   1);
      chk("t3_delay", 32'(delay_b), 3);
      chk("t3_to",    32'(to_b),    0);

      // Back-pressure: arm and line activity during REPORT are ignored
      for (int i = 0; i < 20; i++) begin
         arm_b   = i[0];
         pulse_b = i[1];
         tick();
      end
      arm_b   = 1'b0;
      pulse_b = 1'b0;
      chk("t4_valid", 32'(valid_b), 1);
      chk("t4_width", 32'(width_b), 7);
      chk("t4_ovf",   32'(ovf_b),   1);
      chk("t4_delay", 32'(delay_b), 3);
      chk("t4_to",    32'(to_b),    0);
      ready_b = 1'b1;
      tick();
      ready_b = 1'b0;
      chk("t4_ack_valid", 32'(valid_b), 0);
      chk("t4_ack_busy",  32'(busy_b),  0);
      chk("t4_count",     32'(cnt_b),   1);
      repeat (3) tick();
      chk("t4_idle", 32'(busy_b), 0);

      // Reset during IN_PULSE, then a fresh measurement
      repeat (3) tick();
      arm_a = 1'b1;
      tick();
      arm_a = 1'b0;
      tick();
      pulse_a = 1'b1;
      repeat (4) tick();
      chk("t5_busy_pre", 32'(busy_a), 1);
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
      chk("t5_busy",  32'(busy_a),  0);
      chk("t5_valid", 32'(valid_a), 0);
      chk("t5_count", 32'(cnt_a),   0);
      chk("t5_delay", 32'(delay_a), 0);
      pulse_a = 1'b0;
      repeat (5) tick();
      arm_a = 1'b1;
      tick();
      arm_a = 1'b0;
      repeat (4) tick();
      pulse_a = 1'b1;
      repeat (3) tick();
      pulse_a = 1'b0;
      for (int n = 0; n < 30 && !valid_a; n++) tick();
      chk("t5_wait",   32'(valid_a), 1);
      chk("t5_delay2", 32'(delay_a), 6);
      chk("t5_width2", 32'(width_a), 3);
      ready_a = 1'b1;
      tick();
      ready_a = 1'b0;
      chk("t5_count2", 32'(cnt_a), 1);

      // 1-cycle glitch at +4, 4-cycle pulse at +10
`ifdef PULSE_MONITOR_GLITCH_FILTER_EN
      exp_delay = 11;
      exp_width = 4;
`else
      exp_delay = 5;
      exp_width = 1;
`endif
      repeat (3) tick();
      arm_a = 1'b1;
      tick();
      arm_a = 1'b0;
      repeat (3) tick();
      pulse_a = 1'b1;
      tick();
      pulse_a = 1'b0;
      repeat (5) tick();
      pulse_a = 1'b1;
      repeat (4) tick();
      pulse_a = 1'b0;
      for (int n = 0; n < 40 && !valid_a; n++) tick();
      chk("t6_wait",  32'(valid_a), 1);
      chk("t6_delay", 32'(delay_a), 32'(exp_delay));
      chk("t6_width", 32'(width_a), 32'(exp_width));
      chk("t6_to",    32'(to_a),    0);
      ready_a = 1'b1;
      tick();
      ready_a = 1'b0;
      repeat (10) tick();
      chk("t6_single", 32'(valid_a), 0);
      chk("t6_busy",   32'(busy_a),  0);
      chk("t6_count",  32'(cnt_a),   2);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
